// File: rtl/isqrt_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : isqrt_seq_if
//  Purpose  : Valid/ready handshake bundle for the sequential integer
//             square-root stage (radicand in, root/remainder out).
//  Ports    : in_valid/in_ready/in_radicand  - radicand offer
//             out_valid/out_ready            - result handshake
//             out_root/out_rem               - floor(sqrt(x)) and x - root^2
//             out_root8/out_sat              - 8-bit saturated root, flag
//             busy                           - stage not idle
//  Revision : 1.0  initial release
// ============================================================================
interface isqrt_seq_if #(
    parameter int IN_W = 17
);
    localparam int OUT_W = (IN_W + 1) / 2;

    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_radicand;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_root;
    logic [OUT_W:0]    out_rem;
    logic [7:0]        out_root8;
    logic              out_sat;
    logic              busy;

    // Producer/consumer side that talks to the stage.
    modport master (
        output in_valid, in_radicand, out_ready,
        input  in_ready, out_valid, out_root, out_rem, out_root8, out_sat, busy
    );

    // The square-root stage itself.
    modport slave (
        input  in_valid, in_radicand, out_ready,
        output in_ready, out_valid, out_root, out_rem, out_root8, out_sat, busy
    );
endinterface
`default_nettype wire

// File: rtl/isqrt_seq.sv
`default_nettype none
// ============================================================================
//  Module   : isqrt_seq
//  Purpose  : Bit-serial integer square root, one root bit per cycle.
//             Returns floor(sqrt(x)), the remainder x - root^2, and an 8-bit
//             saturated copy of the root.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous active-high reset
//             bus  - isqrt_seq_if.slave (handshakes and results)
//  Revision : 1.0  initial release
// ============================================================================
module isqrt_seq #(
    parameter int IN_W = 17
) (
    input  wire logic      clk,
    input  wire logic      rst,
    isqrt_seq_if.slave     bus
);
    localparam int OUT_W = (IN_W + 1) / 2;
    localparam int RAD_W = 2 * OUT_W;
    localparam int REM_W = OUT_W + 2;
    localparam int ORM_W = OUT_W + 1;
    localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(OUT_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [RAD_W-1:0]   rad_q,       rad_d;
    logic [OUT_W-1:0]   root_q,      root_d;
    logic [REM_W-1:0]   rem_q,       rem_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [OUT_W-1:0]   res_root_q,  res_root_d;
    logic [ORM_W-1:0]   res_rem_q,   res_rem_d;
    logic [7:0]         res_root8_q, res_root8_d;
    logic               res_sat_q,   res_sat_d;

    logic [REM_W-1:0]   w_rem_shift;
    logic [REM_W-1:0]   w_sub;
    logic [REM_W:0]     w_trial;
    logic               w_trial_ok;
    logic [OUT_W-1:0]   w_root_next;
    logic [REM_W-1:0]   w_rem_next;
    logic [31:0]        w_root_wide;

    // One iteration: bring down the next two radicand bits and try to
    // subtract 4*root+1. The extra top bit of w_trial acts as the sign, so
    // the remainder register itself never needs to hold a negative value.
    always_comb begin
        w_rem_shift = REM_W'({rem_q, rad_q[RAD_W-1 -: 2]});
        w_sub       = REM_W'({root_q, 2'b01});
        w_trial     = {1'b0, w_rem_shift} - {1'b0, w_sub};
        w_trial_ok  = ~w_trial[REM_W];
        w_root_next = OUT_W'({root_q, w_trial_ok});
        w_rem_next  = w_trial_ok ? w_trial[REM_W-1:0] : w_rem_shift;
        w_root_wide = 32'(w_root_next);
    end

    always_comb begin
        state_d     = state_q;
        rad_d       = rad_q;
        root_d      = root_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        res_root_d  = res_root_q;
        res_rem_d   = res_rem_q;
        res_root8_d = res_root8_q;
        res_sat_d   = res_sat_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = ST_CALC;
                    rad_d   = RAD_W'(bus.in_radicand);
                    root_d  = '0;
                    rem_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_CALC: begin
                rad_d  = rad_q << 2;
                root_d = w_root_next;
                rem_d  = w_rem_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST_ITER) begin
                    // Result registers load only here, so they stay
                    // untouched during backpressure and the next CALC.
                    state_d     = ST_DONE;
                    cnt_d       = '0;
                    res_root_d  = w_root_next;
                    res_rem_d   = ORM_W'(w_rem_next);
                    res_sat_d   = (w_root_wide > 32'd255);
                    res_root8_d = (w_root_wide > 32'd255) ? 8'hFF : w_root_wide[7:0];
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rad_q       <= '0;
            root_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            res_root_q  <= '0;
            res_rem_q   <= '0;
            res_root8_q <= '0;
            res_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rad_q       <= rad_d;
            root_q      <= root_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            res_root_q  <= res_root_d;
            res_rem_q   <= res_rem_d;
            res_root8_q <= res_root8_d;
            res_sat_q   <= res_sat_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_root  = res_root_q;
    assign bus.out_rem   = res_rem_q;
    assign bus.out_root8 = res_root8_q;
    assign bus.out_sat   = res_sat_q;
endmodule
`default_nettype wire
